// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared CPU constants and exception encoding
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0a,
    EXC_OV   = 5'h0c
  } exc_code_e;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - fetch-stage redirect, imem and IF/ID bundle
interface inst_fetch_if #(
  parameter int ADDR_W = 32
);

  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              flush;
  logic [ADDR_W-1:0] flush_target;
  logic              inst_ce;
  logic [ADDR_W-1:0] inst_addr;
  logic [31:0]       inst_data;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [31:0]       id_inst;
  logic              id_exc_adel;

  modport master (
    input  stall, branch_taken, branch_target, flush, flush_target, inst_data,
    output inst_ce, inst_addr, id_valid, id_pc, id_inst, id_exc_adel
  );

  modport slave (
    output stall, branch_taken, branch_target, flush, flush_target, inst_data,
    input  inst_ce, inst_addr, id_valid, id_pc, id_inst, id_exc_adel
  );

endinterface

// File: rtl/inst_fetch_if_id_reg.sv
// rtl/inst_fetch_if_id_reg.sv - pipeline boundary register with hold/bubble/load
module if_id_reg #(
  parameter int W = 66
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bubble_i,
  input  logic         hold_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q, data_d;

  // Bubble beats hold so a kill still lands while the hazard unit is stalling.
  always_comb begin
    data_d = data_q;
    if (bubble_i)
      data_d = '0;
    else if (!hold_i && load_i)
      data_d = data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      data_q <= '0;
    else
      data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - MIPS instruction fetch: PC, redirects, pending branch, IF/ID
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF[ADDR_W-1:0]
) (
  input  logic clk,
  input  logic rst_n,
  inst_fetch_if.master bus
);

  localparam int IFID_W = 1 + ADDR_W + 32 + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              run_q;
  logic              pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              aligned;

  assign aligned       = word_aligned(pc_q[1:0]);
  assign bus.inst_addr = pc_q;
  assign bus.inst_ce   = run_q & aligned;

  always_comb begin
    pc_d       = pc_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    if (bus.flush) begin
      pc_d       = bus.flush_target;
      pend_vld_d = 1'b0;
    end else if (!run_q) begin
      pc_d = pc_q;
    end else if (bus.stall) begin
      // A branch resolved during a stall must not be lost; replay it later.
      if (bus.branch_taken) begin
        pend_vld_d = 1'b1;
        pend_tgt_d = bus.branch_target;
      end
    end else if (bus.branch_taken) begin
      pc_d       = bus.branch_target;
      pend_vld_d = 1'b0;
    end else if (pend_vld_q) begin
      pc_d       = pend_tgt_q;
      pend_vld_d = 1'b0;
    end else begin
      pc_d = pc_q + PC_INC[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      run_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      run_q      <= 1'b1;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  logic [IFID_W-1:0] ifid_d, ifid_q;
  logic [31:0]       fetch_word;

  // Misaligned fetches never reach the memory; carry a NOP plus the AdEL flag.
  assign fetch_word = aligned ? bus.inst_data : NOP_WORD;
  assign ifid_d     = {run_q, pc_q, fetch_word, run_q & ~aligned};

  if_id_reg #(
    .W (IFID_W)
  ) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble_i (bus.flush | ~run_q),
    .hold_i   (bus.stall),
    .load_i   (1'b1),
    .data_i   (ifid_d),
    .data_o   (ifid_q)
  );

  assign bus.id_valid    = ifid_q[IFID_W-1];
  assign bus.id_pc       = ifid_q[IFID_W-2 -: ADDR_W];
  assign bus.id_inst     = ifid_q[32:1];
  assign bus.id_exc_adel = ifid_q[0];

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch
module tb_inst_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_if #(.ADDR_W(32)) bus ();

  inst_fetch #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0000_f025;
      32'h0000_0004: mem_word = 32'h241d_1000;
      32'h0000_0008: mem_word = 32'h8f99_0008;
      32'h0000_0010: mem_word = 32'h1080_0003;
      32'h0000_0064: mem_word = 32'h0000_000d;
      32'h0000_0070: mem_word = 32'h3c1c_0000;
      default:       mem_word = {16'hA5A5, a[15:0]};
    endcase
  endfunction

  assign bus.inst_data = mem_word(bus.inst_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  logic ld = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic adel);
    exp_t e;
    e.pc = pc; e.inst = inst; e.adel = adel;
    q.push_back(e);
  endtask

  task automatic cyc(input logic st, input logic br, input logic [31:0] bt,
                     input logic fl, input logic [31:0] ft);
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = bt;
    bus.flush         = fl;
    bus.flush_target  = ft;
    @(posedge clk);
    #2;
  endtask

  // Monitor: an IF/ID entry is new only if the last edge was not a stall.
  always @(posedge clk) ld <= rst_n && !bus.stall;

  always @(negedge clk) begin
    if (ld && bus.id_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got pc %08h expected no entry", bus.id_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_pc", bus.id_pc, e.pc);
        chk("sb_inst", bus.id_inst, e.inst);
        chk("sb_adel", {31'b0, bus.id_exc_adel}, {31'b0, e.adel});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = '0;
    bus.flush = 0; bus.flush_target = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_ce", {31'b0, bus.inst_ce}, 32'h0);
    chk("rst_valid", {31'b0, bus.id_valid}, 32'h0);
    chk("rst_addr", bus.inst_addr, 32'h0);
    chk("rst_id_pc", bus.id_pc, 32'h0);
    chk("rst_id_inst", bus.id_inst, 32'h0);
    chk("rst_adel", {31'b0, bus.id_exc_adel}, 32'h0);

    push(32'h0, 32'h0000_f025, 0);
    push(32'h4, 32'h241d_1000, 0);
    push(32'h8, 32'h8f99_0008, 0);
    push(32'hC, 32'hA5A5_000C, 0);
    push(32'h10, 32'h1080_0003, 0);
    cyc(0, 0, 0, 0, 0);
    chk("boot_ce", {31'b0, bus.inst_ce}, 32'h1);
    chk("boot_addr0", bus.inst_addr, 32'h0);
    cyc(0, 0, 0, 0, 0);
    chk("boot_addr4", bus.inst_addr, 32'h4);
    cyc(0, 0, 0, 0, 0);
    chk("boot_addr8", bus.inst_addr, 32'h8);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("pc_at_10", bus.inst_addr, 32'h10);

    push(32'h70, 32'h3c1c_0000, 0);
    push(32'h74, 32'hA5A5_0074, 0);
    push(32'h78, 32'hA5A5_0078, 0);
    cyc(0, 1, 32'h70, 0, 0);
    chk("br_addr", bus.inst_addr, 32'h70);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    push(32'h20, 32'hA5A5_0020, 0);
    push(32'h40, 32'hA5A5_0040, 0);
    cyc(0, 1, 32'h20, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("stall1_addr", bus.inst_addr, 32'h20);
    chk("stall1_id_pc", bus.id_pc, 32'h78);
    cyc(1, 1, 32'h40, 0, 0);
    chk("stall2_addr", bus.inst_addr, 32'h20);
    chk("stall2_id_pc", bus.id_pc, 32'h78);
    cyc(1, 0, 0, 0, 0);
    chk("stall3_addr", bus.inst_addr, 32'h20);
    chk("stall3_id_inst", bus.id_inst, 32'hA5A5_0078);
    cyc(0, 0, 0, 0, 0);
    chk("pend_addr", bus.inst_addr, 32'h40);
    cyc(0, 0, 0, 0, 0);
    chk("pend_clear_addr", bus.inst_addr, 32'h44);

    push(32'h64, 32'h0000_000d, 0);
    push(32'h68, 32'hA5A5_0068, 0);
    cyc(1, 1, 32'h50, 0, 0);
    cyc(1, 0, 0, 1, 32'h64);
    chk("flush_addr", bus.inst_addr, 32'h64);
    chk("flush_valid", {31'b0, bus.id_valid}, 32'h0);
    cyc(0, 0, 0, 0, 0);
    chk("flush_inst", bus.id_inst, 32'h0000_000d);
    chk("flush_pend_clear", bus.inst_addr, 32'h68);

    push(32'h72, 32'h0, 1);
    push(32'h76, 32'h0, 1);
    cyc(0, 1, 32'h72, 0, 0);
    chk("mis_ce", {31'b0, bus.inst_ce}, 32'h0);
    chk("mis_addr", bus.inst_addr, 32'h72);
    cyc(0, 0, 0, 0, 0);
    chk("mis_adv_addr", bus.inst_addr, 32'h76);
    chk("mis_id_adel", {31'b0, bus.id_exc_adel}, 32'h1);
    chk("mis_id_valid", {31'b0, bus.id_valid}, 32'h1);

    push(32'hFFFF_FFFC, 32'hA5A5_FFFC, 0);
    push(32'h0, 32'h0000_f025, 0);
    push(32'h4, 32'h241d_1000, 0);
    cyc(0, 1, 32'hFFFF_FFFC, 0, 0);
    chk("top_addr", bus.inst_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0);
    chk("wrap_addr", bus.inst_addr, 32'h0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("pre_rst_id_pc", bus.id_pc, 32'h4);

    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ce", {31'b0, bus.inst_ce}, 32'h0);
    chk("arst_addr", bus.inst_addr, 32'h0);
    chk("arst_valid", {31'b0, bus.id_valid}, 32'h0);
    chk("arst_id_pc", bus.id_pc, 32'h0);
    chk("arst_id_inst", bus.id_inst, 32'h0);
    chk("arst_adel", {31'b0, bus.id_exc_adel}, 32'h0);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending expected 0", q.size());
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
